ff_chain_loader: RTL

Controller that sequences a WIDTH-long chain of sync-reset D flip-flops as a serial-in/parallel-out register. It accepts a parallel word over a valid/ready handshake and shifts the word LSB-first into the chain, one bit per enabled tick. It pulses done when the chain holds the word. It sits between a parallel producer and logic that needs a serially-loaded flip-flop bank, such as a display or scan register.

---
 rtl/ff_chain_loader.sv | 84 ++++++++
 1 files changed

// File: rtl/ff_chain_loader.sv
// ff_chain_loader: accepts a parallel word over valid/ready and shifts it
// LSB-first into a WIDTH-long chain of D flip-flops, one bit per enabled tick,
// pulsing done once the chain holds the whole word.
module ff_chain_loader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             tick,
  input  logic             abort,
  input  logic             clear,
  output logic             ser_d,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] chain_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [CNT_W-1:0] count;

  // Handshake and status decode directly from the registered state.
  always_comb begin
    in_ready = (state == IDLE) && !rst;
    busy     = (state != IDLE);
    done     = (state == DONE);
    ser_d    = (state == SHIFT) ? shadow[0] : 1'b0;
    shift_en = (state == SHIFT) && tick && !abort;
  end

  // Load sequencer plus the flip-flop chain it drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      chain_q <= '0;
      shadow  <= '0;
      count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // clear and accept are independent: clear zeroes the chain while
          // the accepted word only lands in the shadow register.
          if (clear) chain_q <= '0;
          if (in_valid) begin
            shadow <= in_data;
            count  <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            count <= '0;
            state <= IDLE;
          end else if (tick) begin
            chain_q <= {shadow[0], chain_q[WIDTH-1:1]};
            shadow  <= shadow >> 1;
            count   <= count + 1'b1;
            if (count == LAST_CNT) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
